// File: rtl/adder_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and datapath widths.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int W     = 4;
  localparam int SUM_W = 5;

endpackage

// File: rtl/four_bit_adder_EC.sv
// Unsigned 4-bit adder with the carry returned as bit 4 of SUM.
module four_bit_adder_EC (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [4:0] SUM
);

  assign SUM = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/four_bit_adder_arbiter.sv
// Two-port round-robin (or fixed-priority) front end sharing one four_bit_adder_EC.
// One operation in flight at a time: IDLE accepts, ADD registers the sum, HOLD waits for the consumer.
module four_bit_adder_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [W:0]   res_sum,
  output logic         res_id,
  input  logic         res_ready,
  output logic         busy
);

  import adder_pkg::*;

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_id;
  logic         r_last_id;
  logic         r_res_valid;
  logic [W:0]   r_res_sum;
  logic         r_res_id;
  logic [W:0]   w_sum;
  logic         w_req0_ready;
  logic         w_req1_ready;

  four_bit_adder_EC u_adder (
    .A   (r_a),
    .B   (r_b),
    .SUM (w_sum)
  );

  // Grant: only in IDLE and out of reset; on contention the port that did not win last goes next.
  always_comb begin
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    if (!reset && (r_state == IDLE)) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && !r_last_id) begin
          w_req1_ready = 1'b1;
        end else begin
          w_req0_ready = 1'b1;
        end
      end else if (req0_valid) begin
        w_req0_ready = 1'b1;
      end else if (req1_valid) begin
        w_req1_ready = 1'b1;
      end else begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
      end
    end else begin
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
    end
  end

  // Operation sequencer: capture winner, register sum, hold until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_id        <= 1'b0;
      r_last_id   <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_sum   <= {(W+1){1'b0}};
      r_res_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0_ready) begin
            r_a       <= req0_a;
            r_b       <= req0_b;
            r_id      <= 1'b0;
            r_last_id <= 1'b0;
            r_state   <= ADD;
          end else if (w_req1_ready) begin
            r_a       <= req1_a;
            r_b       <= req1_b;
            r_id      <= 1'b1;
            r_last_id <= 1'b1;
            r_state   <= ADD;
          end else begin
            r_state <= IDLE;
          end
        end
        ADD: begin
          r_res_sum   <= w_sum;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign res_valid  = r_res_valid;
  assign res_sum    = r_res_sum;
  assign res_id     = r_res_id;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_four_bit_adder_arbiter.sv
// Scoreboard bench: queued requesters drive the round-robin instance, a negedge monitor checks grants,
// results and latency against a transaction-level model; a second instance checks fixed priority.
module tb_four_bit_adder_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_id, res_ready, busy;
  logic [4:0] res_sum;

  logic       f_reset, f_v0, f_r0, f_v1, f_r1, f_res_valid, f_res_id, f_res_ready, f_busy;
  logic [3:0] f_a0, f_b0, f_a1, f_b1;
  logic [4:0] f_res_sum;

  four_bit_adder_arbiter #(.RR_EN(1'b1), .W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id), .res_ready(res_ready), .busy(busy)
  );

  four_bit_adder_arbiter #(.RR_EN(1'b0), .W(4)) dut_fp (
    .clk(clk), .reset(f_reset),
    .req0_valid(f_v0), .req0_a(f_a0), .req0_b(f_b0), .req0_ready(f_r0),
    .req1_valid(f_v1), .req1_a(f_a1), .req1_b(f_b1), .req1_ready(f_r1),
    .res_valid(f_res_valid), .res_sum(f_res_sum), .res_id(f_res_id), .res_ready(f_res_ready),
    .busy(f_busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int valid_pct = 100;
  int rr_pct = 100;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [5:0] exp_q[$];
  int         lat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor and reference model: grants decided by "idle, wants, and didn't go last".
  initial begin : monitor
    bit m_idle = 1'b1;
    bit m_last = 1'b1;
    bit prev_rv = 1'b0;
    bit prev_reset = 1'b0;
    bit g0, g1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
        if (prev_reset) begin
          chk("reset_res_valid", res_valid, 1'b0);
          chk("reset_busy", busy, 1'b0);
        end
        m_idle = 1'b1;
        m_last = 1'b1;
        exp_q.delete();
        lat_q.delete();
        prev_rv = 1'b0;
      end else begin
        g0 = m_idle && req0_valid && (!req1_valid || m_last);
        g1 = m_idle && req1_valid && (!req0_valid || !m_last);
        chk("grant", {req0_ready, req1_ready}, {g0, g1});
        chk("busy", busy, !m_idle);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_res", res_valid, 1'b0);
          end else begin
            chk("result", {res_id, res_sum}, exp_q[0]);
            if (!prev_rv) chk("latency", cyc, lat_q[0] + 2);
            if (res_ready) begin
              void'(exp_q.pop_front());
              void'(lat_q.pop_front());
              m_idle = 1'b1;
            end
          end
        end
        if (g0) begin
          exp_q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
          lat_q.push_back(cyc);
          m_idle = 1'b0;
          m_last = 1'b0;
        end else if (g1) begin
          exp_q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
          lat_q.push_back(cyc);
          m_idle = 1'b0;
          m_last = 1'b1;
        end
        prev_rv = res_valid;
      end
      prev_reset = reset;
    end
  end

  // Requester 0: presents queued operands, holds them until accepted.
  initial begin : drv0
    bit took;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
    forever begin
      @(negedge clk);
      took = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (took) begin void'(src0.pop_front()); req0_valid = 1'b0; end
      if (!req0_valid && src0.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
        req0_a = src0[0][7:4]; req0_b = src0[0][3:0]; req0_valid = 1'b1;
      end
    end
  end

  // Requester 1.
  initial begin : drv1
    bit took;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    forever begin
      @(negedge clk);
      took = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (took) begin void'(src1.pop_front()); req1_valid = 1'b0; end
      if (!req1_valid && src1.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
        req1_a = src1[0][7:4]; req1_b = src1[0][3:0]; req1_valid = 1'b1;
      end
    end
  end

  // Result consumer.
  initial begin : cons
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(0, 99) < rr_pct);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drain(input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (src0.size() == 0 && src1.size() == 0 && !req0_valid && !req1_valid &&
          exp_q.size() == 0 && !busy) break;
    end
    n_total++;
    if (k < maxc) n_pass++;
    else $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + src0.size() + src1.size());
  endtask

  initial begin : main
    int k;
    reset = 1'b1;
    f_reset = 1'b1;
    f_v0 = 1'b0; f_v1 = 1'b0; f_a0 = 4'd6; f_b0 = 4'd7; f_a1 = 4'd2; f_b1 = 4'd3;
    f_res_ready = 1'b1;

    // Reset, then idle with no requests.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single request on port 0.
    src0.push_back({4'd3, 4'd5});
    drain(50);

    // Both ports valid straight out of reset: 0 first, then alternation.
    @(posedge clk); #1 reset = 1'b1;
    src0.push_back({4'd15, 4'd15}); src0.push_back({4'd1, 4'd1}); src0.push_back({4'd2, 4'd2});
    src1.push_back({4'd9, 4'd7});   src1.push_back({4'd3, 4'd3}); src1.push_back({4'd4, 4'd4});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drain(100);

    // Consumer stalls: result must stay stable and the pending request wait.
    rr_pct = 0;
    src0.push_back({4'd1, 4'd2});
    src1.push_back({4'd4, 4'd4});
    for (k = 0; k < 20; k++) begin @(negedge clk); if (res_valid) break; end
    chk("stall_res_seen", res_valid, 1'b1);
    repeat (5) @(negedge clk);
    rr_pct = 100;
    drain(50);

    // Reset during ADD discards the op; next contended grant goes to port 0.
    src0.push_back({4'd2, 4'd2}); src0.push_back({4'd3, 4'd3});
    src1.push_back({4'd5, 4'd5}); src1.push_back({4'd6, 4'd6});
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) break;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midop_res_valid", res_valid, 1'b0);
    chk("midop_busy", busy, 1'b0);
    chk("midop_grant0", {req0_ready, req1_ready}, 2'b10);
    drain(100);

    // Randomized traffic with random gaps and consumer back-pressure.
    rr_pct = 70;
    for (int i = 0; i < 160; i++) begin
      int pick;
      pick = $urandom_range(0, 2);
      valid_pct = $urandom_range(50, 100);
      if (pick != 1) src0.push_back(8'($urandom));
      if (pick != 0) src1.push_back(8'($urandom));
      if (i % 40 == 39) drain(1500);
    end
    valid_pct = 100;
    rr_pct = 100;

    // Every operand pair through port 1.
    for (int ab = 0; ab < 256; ab++) src1.push_back(8'(ab));
    drain(2000);

    // Fixed-priority instance: port 0 always wins while it is valid.
    @(posedge clk); #1 f_reset = 1'b0; f_v0 = 1'b1; f_v1 = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (k = 0; k < 10; k++) begin @(negedge clk); if (f_r0 || f_r1) break; end
      chk("fp_grant0", {f_r0, f_r1}, 2'b10);
      for (k = 0; k < 10; k++) begin @(negedge clk); if (f_res_valid) break; end
      chk("fp_res0", {f_res_id, f_res_sum}, {1'b0, 5'd13});
    end
    @(posedge clk); #1 f_v0 = 1'b0;
    for (k = 0; k < 10; k++) begin @(negedge clk); if (f_r0 || f_r1) break; end
    chk("fp_grant1", {f_r0, f_r1}, 2'b01);
    @(posedge clk); #1 f_v1 = 1'b0;
    for (k = 0; k < 10; k++) begin @(negedge clk); if (f_res_valid) break; end
    chk("fp_res1", {f_res_id, f_res_sum}, {1'b1, 5'd5});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
